// File: rtl/tabla_sweep_ctrl.sv
// Truth-table sweep sequencer: drives every input row into one selected unit, samples Y,
// and compares the table with a golden vector. Optional first-fail tracking: TABLA_FIRST_FAIL_EN.
module tabla_sweep_ctrl #(
  parameter int                 N_FUNCS    = 7,
  parameter logic [N_FUNCS-1:0] FUNC_3IN   = 7'b0100011,
  parameter int                 SETTLE_CYC = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         sel,
  input  logic [15:0]        expected,
  input  logic [N_FUNCS-1:0] func_y,
  output logic [3:0]         in_vec,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               bad_sel,
  output logic [15:0]        result,
  output logic [4:0]         err_count,
  output logic [3:0]         first_fail
);

  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_WAIT, S_SAMPLE, S_DONE} state_t;

  localparam logic [3:0] N_LIM       = 4'(N_FUNCS);
  localparam logic [3:0] SETTLE_LAST = 4'((SETTLE_CYC == 0) ? 0 : SETTLE_CYC - 1);

  state_t     state;
  logic [2:0] sel_reg;
  logic       three_in;
  logic [3:0] row;
  logic [3:0] settle;

  logic       sel_ok;
  logic       y;
  logic       row_bad;
  logic [3:0] last_row;

  assign sel_ok   = ({1'b0, sel} < N_LIM);
  assign y        = func_y[sel_reg];
  assign row_bad  = (y != expected[row]);
  assign last_row = three_in ? 4'd7 : 4'd15;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      sel_reg   <= 3'd0;
      three_in  <= 1'b0;
      row       <= 4'd0;
      settle    <= 4'd0;
      in_vec    <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      bad_sel   <= 1'b0;
      result    <= 16'd0;
      err_count <= 5'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (sel_ok) begin
              sel_reg   <= sel;
              three_in  <= FUNC_3IN[sel];
              result    <= 16'd0;
              err_count <= 5'd0;
              pass      <= 1'b0;
              bad_sel   <= 1'b0;
              row       <= 4'd0;
              busy      <= 1'b1;
              state     <= S_DRIVE;
            end else begin
              // Nonexistent unit: report straight away without touching the bus.
              bad_sel <= 1'b1;
              pass    <= 1'b0;
              state   <= S_DONE;
            end
          end
        end
        S_DRIVE: begin
          in_vec <= three_in ? {1'b0, row[2:0]} : row;
          settle <= 4'd0;
          state  <= (SETTLE_CYC == 0) ? S_SAMPLE : S_WAIT;
        end
        S_WAIT: begin
          settle <= settle + 4'd1;
          if (settle == SETTLE_LAST)
            state <= S_SAMPLE;
        end
        S_SAMPLE: begin
          result[row] <= y;
          if (row_bad)
            err_count <= err_count + 5'd1;
          if (row == last_row) begin
            in_vec <= 4'd0;
            state  <= S_DONE;
          end else begin
            row   <= row + 4'd1;
            state <= S_DRIVE;
          end
        end
        S_DONE: begin
          done   <= 1'b1;
          busy   <= 1'b0;
          pass   <= (err_count == 5'd0) && !bad_sel;
          in_vec <= 4'd0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef TABLA_FIRST_FAIL_EN
  logic [3:0] first_fail_reg;

  // The first mismatch is the one seen while err_count is still zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      first_fail_reg <= 4'd0;
    else if (state == S_IDLE && start && sel_ok)
      first_fail_reg <= 4'd0;
    else if (state == S_SAMPLE && row_bad && err_count == 5'd0)
      first_fail_reg <= row;
  end

  assign first_fail = first_fail_reg;
`else
  assign first_fail = 4'd0;
`endif

endmodule

// File: tb/tb_tabla_sweep_ctrl.sv
// Bench for tabla_sweep_ctrl: behavioural function units plus a table-level reference model.
module tb_tabla_sweep_ctrl;

  localparam int         N_FUNCS  = 7;
  localparam logic [6:0] FUNC_3IN = 7'b0100011;
  localparam int         SETTLE   = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  sel;
  logic [15:0] expected;
  logic [6:0]  func_y;
  logic [3:0]  in_vec;
  logic        busy, done, pass, bad_sel;
  logic [15:0] result;
  logic [4:0]  err_count;
  logic [3:0]  first_fail;

  logic [15:0] tt [N_FUNCS];
  int          checks = 0;
  int          failures = 0;
  bit          sweeping = 0;
  bit          in_vec_bad = 0;
  logic [2:0]  cur_sel = 3'd0;

  always #5 clk = ~clk;

  tabla_sweep_ctrl #(.N_FUNCS(N_FUNCS), .FUNC_3IN(FUNC_3IN), .SETTLE_CYC(SETTLE)) dut (
    .clk(clk), .reset(reset), .start(start), .sel(sel), .expected(expected),
    .func_y(func_y), .in_vec(in_vec), .busy(busy), .done(done), .pass(pass),
    .bad_sel(bad_sel), .result(result), .err_count(err_count), .first_fail(first_fail)
  );

  // Units answer one cycle after the bus changes, so sampling too early is visible.
  always @(posedge clk) begin
    for (int i = 0; i < N_FUNCS; i++)
      func_y[i] <= tt[i][in_vec];
  end

  always @(negedge clk) begin
    if (sweeping && FUNC_3IN[cur_sel] && in_vec[3])
      in_vec_bad = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic run_sweep(input logic [2:0] s, input logic [15:0] e, input bit mid_start);
    bit          good;
    int          rows, cycles, exp_err, exp_ff;
    bit          found;
    logic [15:0] exp_res;
    logic [15:0] t;
    good    = (s < N_FUNCS);
    rows    = 0;
    exp_err = 0;
    exp_ff  = 0;
    found   = 0;
    exp_res = 16'd0;
    if (good) begin
      t    = tt[s];
      rows = FUNC_3IN[s] ? 8 : 16;
      for (int r = 0; r < rows; r++) begin
        exp_res[r] = t[r];
        if (t[r] != e[r]) begin
          exp_err++;
          if (!found) begin
            exp_ff = r;
            found  = 1;
          end
        end
      end
    end
    @(negedge clk);
    sel = s; expected = e; start = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    cur_sel    = s;
    in_vec_bad = 1'b0;
    sweeping   = good;
    check("busy_on_accept", busy, good);
    cycles = 0;
    while (!done && cycles < 300) begin
      @(negedge clk);
      if (mid_start && cycles == 7) begin
        start = 1'b1;
        sel   = s ^ 3'd2;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    start    = 1'b0;
    sweeping = 0;
    $display("sweep sel=%0d exp=%04h result=%04h err=%0d pass=%0b bad_sel=%0b cycles=%0d",
             s, e, result, err_count, pass, bad_sel, cycles);
    check("done_latency", cycles, good ? rows * (SETTLE + 2) + 1 : 1);
    check("bad_sel", bad_sel, !good);
    check("pass", pass, good && exp_err == 0);
    check("busy_at_done", busy, 0);
    check("in_vec_at_done", in_vec, 0);
    if (good) begin
      check("result", result, exp_res);
      check("err_count", err_count, exp_err);
      check("in_vec_a_3in", in_vec_bad, 0);
`ifdef TABLA_FIRST_FAIL_EN
      check("first_fail", first_fail, exp_ff);
`else
      check("first_fail", first_fail, 0);
`endif
    end
    @(posedge clk);
    #1;
    check("done_pulse", done, 0);
    if (good) check("result_hold", result, exp_res);
  endtask

  initial begin
    int dcount;
    logic [2:0]  s;
    logic [15:0] e;
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          dcount;
    logic [2:0]  s;
    logic [15:0] e;
    for (int i = 0; i < N_FUNCS; i++) tt[i] = 16'd0;
    reset = 1'b1; start = 1'b0; sel = 3'd0; expected = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_outputs", {in_vec, done, pass, bad_sel, err_count, first_fail}, 0);
    check("rst_result", result, 0);
    @(negedge clk);
    reset = 1'b0;

    // Directed cases from the unit list.
    tt[1] = 16'h0033; tt[5] = 16'h00BB; tt[3] = 16'hFDA5;
    run_sweep(3'd1, 16'h0033, 0);
    run_sweep(3'd5, 16'h00BF, 0);
    run_sweep(3'd3, 16'hFDA5, 0);
    run_sweep(3'd7, 16'h1234, 0);
    check("bad_in_vec", in_vec, 0);

    // Reset during row 5 of a 16-row sweep.
    @(negedge clk);
    sel = 3'd3; expected = 16'hFDA5; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (16) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_in_vec", in_vec, 0);
    check("midrst_result", result, 0);
    @(negedge clk);
    reset = 1'b0;
    dcount = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    check("midrst_no_done", dcount, 0);
    run_sweep(3'd3, 16'hFDA5, 0);

    // Start pulsed while busy must not disturb the sweep.
    run_sweep(3'd3, 16'hFDA5, 1);
    run_sweep(3'd0, 16'h0000, 1);

    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < N_FUNCS; i++) tt[i] = 16'($urandom);
      s = 3'($urandom_range(0, 7));
      e = (s < N_FUNCS) ? tt[s] : 16'($urandom);
      if ($urandom_range(0, 1) == 1) e = e ^ (16'd1 << $urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) e = e ^ (16'd1 << $urandom_range(0, 15));
      run_sweep(s, e, $urandom_range(0, 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
